// File: rtl/ysyx_23060077_div_ctrl.sv
// Issue-side controller for the iterative divider: corner cases, one-at-a-time issue, flush drain.
// Define YSYX_23060077_DIV_CACHE_EN to add a single-entry quotient/remainder cache.
module ysyx_23060077_div_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            div_op,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic                  flush,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  div_signed,
  output logic [DATA_WIDTH-1:0] dividend,
  output logic [DATA_WIDTH-1:0] divisor,
  output logic                  div_flush,
  output logic                  div_valid,
  input  logic                  div_ready,
  input  logic                  div_out_valid,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder
);

  // state | meaning
  // IDLE  | accepting ops, corner cases and cache hits resolve here
  // ISSUE | request offered to divider when it is ready
  // WAIT  | divider busy on our op
  // DONE  | result presented to writeback
  // DRAIN | flushed op still in divider, swallow its completion
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_e;

  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] dividend_q, dividend_d;
  logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  signed_q, signed_d;
  logic                  rem_q, rem_d;

  logic                  in_rem, in_signed, div_by_zero, overflow, corner, accept;
  logic                  cache_hit, div_done;
  logic [DATA_WIDTH-1:0] corner_res, cache_res;

  always_comb begin
    in_rem      = div_op[1];
    in_signed   = ~div_op[0];
    div_by_zero = (src2 == '0);
    overflow    = in_signed && (src1 == MIN_NEG) && (src2 == ALL_ONES);
    corner      = div_by_zero || overflow;
    if (div_by_zero) corner_res = in_rem ? src1 : ALL_ONES;
    else             corner_res = in_rem ? '0 : MIN_NEG;
    accept   = (state_q == S_IDLE) && in_valid && !flush;
    div_done = (state_q == S_WAIT) && div_out_valid && !flush;
  end

`ifdef YSYX_23060077_DIV_CACHE_EN
  logic [DATA_WIDTH-1:0] c_src1_q, c_src1_d, c_src2_q, c_src2_d;
  logic [DATA_WIDTH-1:0] c_quot_q, c_quot_d, c_rem_q, c_rem_d;
  logic                  c_signed_q, c_signed_d, c_valid_q, c_valid_d;

  always_comb begin
    c_src1_d   = c_src1_q;
    c_src2_d   = c_src2_q;
    c_quot_d   = c_quot_q;
    c_rem_d    = c_rem_q;
    c_signed_d = c_signed_q;
    c_valid_d  = c_valid_q;
    if (div_done) begin
      c_src1_d   = dividend_q;
      c_src2_d   = divisor_q;
      c_quot_d   = div_quotient;
      c_rem_d    = div_remainder;
      c_signed_d = signed_q;
      c_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      c_src1_q   <= '0;
      c_src2_q   <= '0;
      c_quot_q   <= '0;
      c_rem_q    <= '0;
      c_signed_q <= 1'b0;
      c_valid_q  <= 1'b0;
    end else begin
      c_src1_q   <= c_src1_d;
      c_src2_q   <= c_src2_d;
      c_quot_q   <= c_quot_d;
      c_rem_q    <= c_rem_d;
      c_signed_q <= c_signed_d;
      c_valid_q  <= c_valid_d;
    end
  end

  assign cache_hit = c_valid_q && (c_src1_q == src1) && (c_src2_q == src2) &&
                     (c_signed_q == in_signed);
  assign cache_res = in_rem ? c_rem_q : c_quot_q;
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      signed_q   <= 1'b0;
      rem_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      signed_q   <= signed_d;
      rem_q      <= rem_d;
    end
  end

  // A flush coinciding with the completion pulse just drops it; DRAIN would wait forever.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (corner || cache_hit) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (div_ready)  state_d = flush ? S_DRAIN : S_WAIT;
        else if (flush) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (flush)              state_d = div_out_valid ? S_IDLE : S_DRAIN;
        else if (div_out_valid) state_d = S_DONE;
      end
      S_DONE:  if (flush || res_ready) state_d = S_IDLE;
      S_DRAIN: if (div_out_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    signed_d   = signed_q;
    rem_d      = rem_q;
    result_d   = result_q;
    if (accept) begin
      dividend_d = src1;
      divisor_d  = src2;
      signed_d   = in_signed;
      rem_d      = in_rem;
      if (corner)         result_d = corner_res;
      else if (cache_hit) result_d = cache_res;
    end
    if (div_done) result_d = rem_q ? div_remainder : div_quotient;
  end

  always_comb begin
    in_ready   = (state_q == S_IDLE) && !reset;
    res_valid  = (state_q == S_DONE);
    div_valid  = (state_q == S_ISSUE) && div_ready;
    result     = result_q;
    dividend   = dividend_q;
    divisor    = divisor_q;
    div_signed = signed_q;
    div_flush  = flush;
  end

endmodule

// File: tb/tb_ysyx_23060077_div_ctrl.sv
// Self-checking bench for ysyx_23060077_div_ctrl with a behavioural divider and result model.
// Honours YSYX_23060077_DIV_CACHE_EN when it is defined for the build.
module tb_ysyx_23060077_div_ctrl;
`ifdef YSYX_23060077_DIV_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clock = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, res_ready = 1'b0;
  logic        div_ready = 1'b0, div_out_valid = 1'b0;
  logic [1:0]  div_op = 2'd0;
  logic [31:0] src1 = '0, src2 = '0, div_quotient = '0, div_remainder = '0;
  logic        in_ready, res_valid, div_signed, div_flush, div_valid;
  logic [31:0] result, dividend, divisor;

  ysyx_23060077_div_ctrl #(.DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .div_op(div_op), .src1(src1), .src2(src2), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
    .div_flush(div_flush), .div_valid(div_valid), .div_ready(div_ready),
    .div_out_valid(div_out_valid), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clock = ~clock;

  int tests = 0, errors = 0, cycle = 0;
  logic        s_in_ready, s_res_valid, s_accept;
  logic [31:0] s_result;
  int hs_cnt = 0, dv_cnt = 0, ov_cnt = 0, rv_rise = 0, mon_viol = 0, last_ov_cycle = -10;
  int ov_at_accept = 0;
  logic last_rv = 1'b0;

  // divider model state
  bit          busy = 1'b0, hs = 1'b0;
  int          cnt = 0, lat_min = 2, lat_max = 2, gate_pct = 100;
  logic [31:0] cap_a = '0, cap_b = '0;
  logic        cap_s = 1'b0;

  // architectural result model state (single-entry cache)
  bit          cm_valid = 1'b0, cm_s = 1'b0;
  logic [31:0] cm_a = '0, cm_b = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          hs_nc;
    int          hs_c;
  } vec_t;
  vec_t vecs[14];

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
      return op[1] ? sa % sb : sa / sb;
    end
    return op[1] ? a % b : a / b;
  endfunction

  function automatic int mexp_hs(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic s;
    s = ~op[0];
    if (b == 32'd0) return 0;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    if (CACHE && cm_valid && cm_a == a && cm_b == b && cm_s == s) return 0;
    return 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Sample mid-cycle, then advance the divider model just after the rising edge.
  task automatic step();
    @(negedge clock);
    cycle++;
    s_in_ready  = in_ready;
    s_res_valid = res_valid;
    s_result    = result;
    s_accept    = in_ready && in_valid && !flush;
    hs          = div_valid && div_ready;
    if (hs) begin
      hs_cnt++;
      cap_a = dividend;
      cap_b = divisor;
      cap_s = div_signed;
    end
    if (div_valid) dv_cnt++;
    if (div_valid && !div_ready) mon_viol++;
    if (div_flush !== flush) mon_viol++;
    if ((busy || div_out_valid) && (dividend !== cap_a || divisor !== cap_b || div_signed !== cap_s))
      mon_viol++;
    if (div_out_valid) begin
      ov_cnt++;
      last_ov_cycle = cycle;
    end
    if (res_valid && !last_rv) rv_rise++;
    last_rv = res_valid;
    @(posedge clock);
    #1;
    div_out_valid = 1'b0;
    div_quotient  = $urandom;
    div_remainder = $urandom;
    if (reset) busy = 1'b0;
    else if (hs) begin
      busy = 1'b1;
      cnt  = $urandom_range(lat_max, lat_min);
    end else if (busy) begin
      cnt--;
      if (cnt == 0) begin
        busy          = 1'b0;
        div_out_valid = 1'b1;
        div_quotient  = ref_div({1'b0, ~cap_s}, cap_a, cap_b);
        div_remainder = ref_div({1'b1, ~cap_s}, cap_a, cap_b);
      end
    end
    div_ready = !busy && !div_out_valid && ($urandom_range(99, 0) < gate_pct);
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_hs,
                       input int hold);
    int n, hs0, dv0, ok;
    hs0 = hs_cnt;
    dv0 = dv_cnt;
    in_valid = 1'b1;
    div_op = op;
    src1 = a;
    src2 = b;
    n = 0;
    do begin
      step();
      n++;
    end while (!s_accept && n < 200);
    ov_at_accept = ov_cnt;
    in_valid = 1'b0;
    div_op = 2'($urandom);
    src1 = $urandom;
    src2 = $urandom;
    if (!s_accept) begin
      check1({name, " accept timeout"}, 1'b0, 1'b1);
      return;
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!s_res_valid && n < 300);
    check1({name, " res_valid"}, s_res_valid, 1'b1);
    check({name, " result"}, s_result, exp);
    if (exp_hs == 0) check({name, " latency"}, n, 1);
    else check({name, " ov to res"}, cycle, last_ov_cycle + 1);
    ok = 1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!s_res_valid || s_result !== exp || s_in_ready) ok = 0;
    end
    if (hold > 0) check({name, " hold"}, ok, 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    step();
    check1({name, " in_ready after"}, s_in_ready, 1'b1);
    check({name, " div requests"}, hs_cnt - hs0, exp_hs);
    check({name, " div_valid cycles"}, dv_cnt - dv0, exp_hs);
    if (exp_hs == 1) begin
      cm_valid = 1'b1;
      cm_a = a;
      cm_b = b;
      cm_s = ~op[0];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, ov0, rv0, n;
    logic [1:0]  op;
    logic [31:0] a, b, pa, pb;

    vecs[0]  = '{2'd0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1, 1};
    vecs[1]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1, 0};
    vecs[2]  = '{2'd1, 32'd100,       32'd0,        32'hFFFF_FFFF, 0, 0};
    vecs[3]  = '{2'd3, 32'd100,       32'd0,        32'd100,       0, 0};
    vecs[4]  = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0};
    vecs[5]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0, 0};
    vecs[6]  = '{2'd1, 32'd20,        32'd6,        32'd3,         1, 1};
    vecs[7]  = '{2'd0, 32'd20,        32'd6,        32'd3,         1, 1};
    vecs[8]  = '{2'd0, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 1, 1};
    vecs[9]  = '{2'd2, 32'd20,        32'hFFFF_FFFD, 32'd2,         1, 0};
    vecs[10] = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1};
    vecs[11] = '{2'd3, 32'd7,         32'hFFFF_FFFF, 32'd7,         1, 1};
    vecs[12] = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1, 1};
    vecs[13] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1, 1};

    reset = 1'b1;
    step();
    step();
    check1("reset in_ready", in_ready, 1'b0);
    check1("reset res_valid", res_valid, 1'b0);
    check1("reset div_valid", div_valid, 1'b0);
    check1("reset div_signed", div_signed, 1'b0);
    check("reset result", result, 32'h0);
    check("reset dividend", dividend, 32'h0);
    check("reset divisor", divisor, 32'h0);
    reset = 1'b0;
    step();
    check1("in_ready after reset", s_in_ready, 1'b1);

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
            CACHE ? vecs[i].hs_c : vecs[i].hs_nc, 0);

    do_op("hold", 2'd1, 32'd20, 32'd6, 32'd3, mexp_hs(2'd1, 32'd20, 32'd6), 5);

    // flush in IDLE together with in_valid: nothing accepted
    in_valid = 1'b1; div_op = 2'd1; src1 = 32'd5; src2 = 32'd0; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    step();
    check1("flush idle in_ready", s_in_ready, 1'b1);
    check1("flush idle res_valid", s_res_valid, 1'b0);

    // flush while result is presented
    in_valid = 1'b1; div_op = 2'd3; src1 = 32'd9; src2 = 32'd0;
    step();
    in_valid = 1'b0;
    step();
    check1("flush done pre res_valid", s_res_valid, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check1("flush done res_valid", s_res_valid, 1'b0);
    check1("flush done in_ready", s_in_ready, 1'b1);

    // flush in ISSUE while divider not ready
    hs0 = hs_cnt;
    gate_pct = 0;
    in_valid = 1'b1; div_op = 2'd1; src1 = 32'd50; src2 = 32'd7;
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; gate_pct = 100;
    step();
    check1("flush issue in_ready", s_in_ready, 1'b1);
    check("flush issue no request", hs_cnt - hs0, 0);

    // flush two cycles after handshake, stale completion must be drained
    lat_min = 6; lat_max = 6;
    hs0 = hs_cnt; ov0 = ov_cnt; rv0 = rv_rise;
    in_valid = 1'b1; div_op = 2'd1; src1 = 32'd50; src2 = 32'd7;
    step();
    in_valid = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (hs_cnt == hs0 && n < 50);
    check("drain handshake seen", hs_cnt - hs0, 1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    do_op("after flush", 2'd1, 32'd9, 32'd3, 32'd3, mexp_hs(2'd1, 32'd9, 32'd3), 0);
    check("stale ov before accept", ov_at_accept - ov0, 1);
    check("single res_valid after flush", rv_rise - rv0, 1);

    // reset mid-operation
    hs0 = hs_cnt;
    in_valid = 1'b1; div_op = 2'd1; src1 = 32'd50; src2 = 32'd7;
    step();
    in_valid = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (hs_cnt == hs0 && n < 50);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cm_valid = 1'b0;
    step();
    check1("mid reset in_ready", s_in_ready, 1'b1);
    check1("mid reset res_valid", s_res_valid, 1'b0);
    do_op("post reset", 2'd1, 32'd50, 32'd7, 32'd7, mexp_hs(2'd1, 32'd50, 32'd7), 0);

    // randomized ops against the reference model
    lat_min = 2; lat_max = 8; gate_pct = 70;
    pa = 32'd1; pb = 32'd1;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(3, 0));
      case ($urandom_range(5, 0))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = pa; b = pb; end
        default: begin a = $urandom; b = $urandom >> $urandom_range(31, 0); end
      endcase
      pa = a; pb = b;
      do_op($sformatf("rnd%0d", i), op, a, b, ref_div(op, a, b), mexp_hs(op, a, b),
            $urandom_range(2, 0));
    end

    check("monitor violations", mon_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060077_div_ctrl.md
# ysyx_23060077_div_ctrl

Issue-side controller for the iterative 32-bit divider in the EX stage. Accepts RISC-V M-extension divide/remainder ops (DIV, DIVU, REM, REMU) from the EX dispatch, resolves the architectural corner cases locally, and sequences one request at a time into the divider over its valid/ready/out_valid handshake. It holds the divider operands stable for the whole operation, drops results orphaned by a pipeline flush, and presents a single selected result to writeback over a valid/ready handshake.

## Interface
- DATA_WIDTH, 32, operand/result width; must equal the divider width (32)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream op valid
- in_ready  out  1  controller can accept an op (high only in IDLE)
- div_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- src1  in  32  dividend (rs1)
- src2  in  32  divisor (rs2)
- flush  in  1  kill the in-flight op
- res_valid  out  1  result available
- res_ready  in  1  writeback accepts result
- result  out  32  quotient or remainder per div_op
- div_signed  out  1  to divider: signed op
- dividend  out  32  to divider
- divisor  out  32  to divider
- div_flush  out  1  to divider flush; mirrors flush
- div_valid  out  1  request to divider
- div_ready  in  1  divider idle and able to accept
- div_out_valid  in  1  one-cycle completion pulse from divider
- div_quotient  in  32  divider quotient
- div_remainder  in  32  divider remainder

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE: in_ready=1. On in_valid, latch src1, src2, div_op into operand registers. If src2==0: result = (REM/REMU) ? src1 : 32'hFFFF_FFFF; go to DONE. If signed op, src1==32'h8000_0000 and src2==32'hFFFF_FFFF: result = (DIV) ? 32'h8000_0000 : 0; go to DONE. Otherwise go to ISSUE.
- ISSUE: div_valid = div_ready (combinational). When div_ready=1, the request is taken that cycle; go to WAIT.
- WAIT: on div_out_valid, capture div_quotient (DIV/DIVU) or div_remainder (REM/REMU) into the result register; go to DONE.
- DONE: res_valid=1; on res_ready, go to IDLE.
- DRAIN: entered on flush in WAIT, or in ISSUE when div_valid&&div_ready in the same cycle. Ignore all inputs. On div_out_valid, discard and go to IDLE.
- Flush in IDLE, DONE, or ISSUE without the handshake: go to IDLE with no result. Flush takes priority over res_ready, div_out_valid, and in_valid in the same cycle.
- dividend, divisor, and div_signed come only from the operand registers and stay constant from ISSUE through the div_out_valid cycle, including in DRAIN. div_signed = (div_op is DIV or REM). The divider re-reads the operand signs when forming its final result.
- At most one divider operation is outstanding. A new op is never issued while in DRAIN.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1 in IDLE. res_valid=0, result=0, div_valid=0, div_signed=0, dividend=0, divisor=0, state=IDLE.
- Corner-case latency: accept at cycle N, res_valid at N+1.
- Normal latency: accept at N; ISSUE at N+1; divider handshake at the first cycle ≥N+1 with div_ready=1; res_valid one cycle after the div_out_valid pulse.
- div_valid is never asserted while div_ready=0, because the divider samples requests in its idle state regardless.
- result and res_valid are held stable until res_ready. Back-to-back: in_ready returns the cycle after res_valid&&res_ready.
- Reset mid-operation: the controller and divider both return to idle. No drain is required.

## Configuration
- YSYX_23060077_DIV_CACHE_EN defined: add one entry holding {src1, src2, div_signed, quotient, remainder, valid}.
  - Written on every completed, non-flushed divider result.
  - Cleared by reset only.
  - In IDLE, a non-corner op whose src1, src2, and signedness match a valid entry goes directly to DONE (N+1) and returns the cached quotient or remainder without touching the divider. This covers DIV followed by REM on the same operands.
- Undefined: no cache; every non-corner op goes through the divider.

## Test plan
- DIV src1=-7 (32'hFFFF_FFF9), src2=2 -> result 32'hFFFF_FFFD; REM on the same operands -> 32'hFFFF_FFFF; div_valid high exactly one cycle per op.
- DIVU src1=100, src2=0 -> result 32'hFFFF_FFFF at N+1, div_valid never asserted; REMU 100/0 -> 100.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000 at N+1; REM on the same operands -> 0.
- Flush two cycles after div_valid handshake, then a new DIVU 9/3 -> in_ready stays low until the stale div_out_valid has been discarded; the new result is 3, and the stale result is never on res_valid.
- res_ready held low for 5 cycles after DIVU 20/6 -> result 3 held stable with res_valid high; in_ready=0 throughout.
- With YSYX_23060077_DIV_CACHE_EN defined: DIV 20/-3 then REM 20/-3 -> 32'hFFFF_FFFA (-6), then 2 at N+1 with no div_valid; without the macro, the second op reissues to the divider.
